// File: rtl/tournament_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tournament_pkg
// Purpose  : Shared widths, types and helpers for the tournament predictor
//            stages (local history stage and global/choice stage).
// Revision : 1.0 - initial release
// ============================================================================
package tournament_pkg;

  localparam int PC_W      = 32;
  localparam int LHT_IDX_W = 10;
  localparam int HIST_W    = 10;
  localparam int CNT_W     = 3;

  typedef logic [HIST_W-1:0]    hist_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [LHT_IDX_W-1:0] lht_idx_t;

  // Weakly not-taken starting point for every counter
  localparam cnt_t CNT_INIT = cnt_t'(3);

  // Saturating up/down counter step, shared by all counter tables
  function automatic cnt_t sat_update(input cnt_t c, input logic taken);
    cnt_t r;
    if (taken) r = (c == '1) ? c : cnt_t'(c + 1'b1);
    else       r = (c == '0) ? c : cnt_t'(c - 1'b1);
    return r;
  endfunction

  // Word-aligned branch address bits select the history entry
  function automatic lht_idx_t lht_index(input logic [PC_W-1:0] pc);
    return pc[LHT_IDX_W+1:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/local_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : local_predictor_if
// Purpose  : Predict/update request bus and prediction result of the local
//            predictor stage.
// Revision : 1.0 - initial release
// ============================================================================
interface local_predictor_if;
  import tournament_pkg::*;

  logic            PredictValid;
  logic [PC_W-1:0] PC;
  logic            UpdateValid;
  logic            BranchTaken;
  logic            LPresult;
  logic            LPvalid;

  modport master (
    output PredictValid, PC, UpdateValid, BranchTaken,
    input  LPresult, LPvalid
  );

  modport slave (
    input  PredictValid, PC, UpdateValid, BranchTaken,
    output LPresult, LPvalid
  );

endinterface
`default_nettype wire

// File: rtl/local_history_table.sv
`default_nettype none
// ============================================================================
// Module   : local_history_table
// Purpose  : Per-branch history registers. One combinational read port for
//            the predict index, one for the pending entry, and a shift-in
//            write into the pending entry.
// Revision : 1.0 - initial release
// ============================================================================
module local_history_table
  import tournament_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  lht_idx_t rd_idx,
  output hist_t    rd_hist,
  input  lht_idx_t pend_idx,
  output hist_t    pend_shifted,
  input  logic     wr_en,
  input  logic     wr_bit
);

  localparam int c_DEPTH = 2 ** LHT_IDX_W;

  hist_t r_lht [c_DEPTH];
  hist_t w_pend_cur;

  // Read ports and the shifted value that an update would write back
  always_comb begin
    rd_hist      = r_lht[rd_idx];
    w_pend_cur   = r_lht[pend_idx];
    pend_shifted = {w_pend_cur[HIST_W-2:0], wr_bit};
  end

  // Table clear on reset, shift outcome into the pending entry on update
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) r_lht[i] <= '0;
    end else if (wr_en) begin
      r_lht[pend_idx] <= pend_shifted;
    end
  end

endmodule
`default_nettype wire

// File: rtl/local_predictor.sv
`default_nettype none
// ============================================================================
// Module   : local_predictor
// Purpose  : Local-history predictor: PC -> history -> 3-bit counter; the
//            counter MSB is the registered prediction. One branch is
//            outstanding; same-cycle update is bypassed into the predict.
// Revision : 1.0 - initial release
// ============================================================================
module local_predictor
  import tournament_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  local_predictor_if.slave        bus
);

  localparam int c_LPT_DEPTH = 2 ** HIST_W;

  cnt_t     r_lpt [c_LPT_DEPTH];
  logic     r_pending;
  lht_idx_t r_pend_idx;
  hist_t    r_pend_hist;
  logic     r_lpresult;
  logic     r_lpvalid;

  logic     w_upd;
  lht_idx_t w_idx;
  hist_t    w_rd_hist;
  hist_t    w_shifted;
  hist_t    w_hist;
  cnt_t     w_cnt_new;
  cnt_t     w_cnt;

  local_history_table u_lht (
    .clock        (clock),
    .reset        (reset),
    .rd_idx       (w_idx),
    .rd_hist      (w_rd_hist),
    .pend_idx     (r_pend_idx),
    .pend_shifted (w_shifted),
    .wr_en        (w_upd),
    .wr_bit       (bus.BranchTaken)
  );

  // Lookup with bypass: a same-cycle update is visible to the new predict
  always_comb begin
    w_upd     = r_pending & bus.UpdateValid;
    w_idx     = lht_index(bus.PC);
    w_hist    = (w_upd && (w_idx == r_pend_idx)) ? w_shifted : w_rd_hist;
    w_cnt_new = sat_update(r_lpt[r_pend_hist], bus.BranchTaken);
    w_cnt     = (w_upd && (w_hist == r_pend_hist)) ? w_cnt_new : r_lpt[w_hist];
  end

  // Counter table: reset to weakly not-taken, train the pending entry
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < c_LPT_DEPTH; i++) r_lpt[i] <= CNT_INIT;
    end else if (w_upd) begin
      r_lpt[r_pend_hist] <= w_cnt_new;
    end
  end

  // Prediction output and pending-branch bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lpresult  <= 1'b0;
      r_lpvalid   <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_hist <= '0;
    end else begin
      r_lpvalid <= bus.PredictValid;
      if (bus.PredictValid) begin
        r_lpresult  <= w_cnt[CNT_W-1];
        r_pending   <= 1'b1;
        r_pend_idx  <= w_idx;
        r_pend_hist <= w_hist;
      end else if (w_upd) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.LPresult = r_lpresult;
  assign bus.LPvalid  = r_lpvalid;

endmodule
`default_nettype wire

// File: tb/tb_local_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_predictor
// Purpose  : Self-checking bench: directed scenarios with literal results
//            plus randomized traffic against a table-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_local_predictor;
  import tournament_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  local_predictor_if bus ();

  local_predictor dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_lht [1024];
  int m_lpt [1024];
  bit m_pend;
  int m_pi;
  int m_ph;
  bit exp_valid;
  bit exp_result;
  bit armed = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: apply the resolving update first, then predict on the
  // resulting tables
  always @(posedge clock) begin
    int i;
    int h;
    bit upd;
    if (reset) begin
      for (int k = 0; k < 1024; k++) begin
        m_lht[k] = 0;
        m_lpt[k] = 3;
      end
      m_pend     = 0;
      exp_valid  = 0;
      exp_result = 0;
      armed      = 1;
    end else begin
      upd = bus.UpdateValid && m_pend;
      if (upd) begin
        if (bus.BranchTaken) m_lpt[m_ph] = (m_lpt[m_ph] == 7) ? 7 : m_lpt[m_ph] + 1;
        else                 m_lpt[m_ph] = (m_lpt[m_ph] == 0) ? 0 : m_lpt[m_ph] - 1;
        m_lht[m_pi] = ((m_lht[m_pi] * 2) + (bus.BranchTaken ? 1 : 0)) % 1024;
      end
      if (bus.PredictValid) begin
        i          = (bus.PC / 4) % 1024;
        h          = m_lht[i];
        exp_result = (m_lpt[h] >= 4);
        exp_valid  = 1;
        m_pend     = 1;
        m_pi       = i;
        m_ph       = h;
      end else begin
        exp_valid = 0;
        if (upd) m_pend = 0;
      end
    end
  end

  // Every-cycle output comparison against the model
  always @(negedge clock) begin
    if (armed) begin
      chk("LPvalid", int'(bus.LPvalid), int'(exp_valid));
      chk("LPresult", int'(bus.LPresult), int'(exp_result));
    end
  end

  task automatic cyc(input bit pv, input logic [31:0] pc, input bit uv,
                     input bit bt, input bit rs);
    reset            = rs;
    bus.PredictValid = pv;
    bus.PC           = pc;
    bus.UpdateValid  = uv;
    bus.BranchTaken  = bt;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 4; k++) cyc(0, 32'h0, 0, 0, 1);
  endtask

  initial begin
    bus.PredictValid = 0;
    bus.PC           = '0;
    bus.UpdateValid  = 0;
    bus.BranchTaken  = 0;

    // Reset state
    do_reset();
    chk("rst_LPvalid", int'(bus.LPvalid), 0);
    chk("rst_LPresult", int'(bus.LPresult), 0);

    // Spurious update with nothing pending, then first predict
    cyc(0, 32'h0, 1, 1, 0);
    chk("model_spurious_lht", m_lht[64], 0);
    cyc(1, 32'h100, 0, 0, 0);
    chk("first_pred_valid", int'(bus.LPvalid), 1);
    chk("first_pred_result", int'(bus.LPresult), 0);
    cyc(0, 32'h0, 0, 0, 0);
    chk("idle_LPvalid", int'(bus.LPvalid), 0);

    // Always taken
    for (int k = 0; k < 20; k++) begin
      cyc(1, 32'h100, 0, 0, 0);
      chk("taken_pred", int'(bus.LPresult), (k >= 11) ? 1 : 0);
      cyc(0, 32'h0, 1, 1, 0);
    end
    chk("model_lht_all_ones", m_lht[64], 32'h3FF);
    chk("model_lpt_saturated", m_lpt[1023], 7);

    // Then always not taken
    for (int k = 0; k < 20; k++) begin
      cyc(1, 32'h100, 0, 0, 0);
      if (k == 0 || k == 10)  chk("nt_pred_hi", int'(bus.LPresult), 1);
      else if (k < 10)        chk("nt_pred_lo", int'(bus.LPresult), 0);
      cyc(0, 32'h0, 1, 0, 0);
      if (k == 9) chk("model_lht_cleared", m_lht[64], 0);
    end
    chk("model_lpt_3ff", m_lpt[1023], 6);

    // Counter bypass: same history, updated counter used immediately
    do_reset();
    cyc(1, 32'h100, 0, 0, 0);
    cyc(1, 32'h200, 1, 1, 0);
    chk("cnt_bypass", int'(bus.LPresult), 1);
    cyc(0, 32'h0, 1, 0, 0);

    // History bypass: LPT[0]=2, LPT[1]=4, then update+predict on same index
    do_reset();
    cyc(1, 32'h200, 0, 0, 0); cyc(0, 32'h0, 1, 1, 0);
    cyc(1, 32'h200, 0, 0, 0); cyc(0, 32'h0, 1, 1, 0);
    cyc(1, 32'h300, 0, 0, 0); cyc(0, 32'h0, 1, 0, 0);
    cyc(1, 32'h300, 0, 0, 0); cyc(0, 32'h0, 1, 0, 0);
    cyc(1, 32'h100, 0, 0, 0);
    chk("hist_bypass_pre", int'(bus.LPresult), 0);
    cyc(1, 32'h100, 1, 1, 0);
    chk("hist_bypass", int'(bus.LPresult), 1);
    chk("model_bypass_hist", m_ph, 1);
    cyc(0, 32'h0, 1, 0, 0);

    // Overwritten pending entry: only the latest predict is trained
    do_reset();
    cyc(1, 32'h100, 0, 0, 0);
    cyc(1, 32'h200, 0, 0, 0);
    cyc(0, 32'h0, 1, 1, 0);
    chk("model_ovw_lht80", m_lht[128], 1);
    chk("model_ovw_lht40", m_lht[64], 0);
    cyc(1, 32'h100, 0, 0, 0);
    chk("ovw_pred", int'(bus.LPresult), 1);

    // Reset mid-operation discards the concurrent update
    cyc(0, 32'h0, 1, 1, 1);
    cyc(1, 32'h100, 0, 0, 0);
    chk("rst_mid_pred", int'(bus.LPresult), 0);

    // Aliasing: 0x1100 shares the history entry of 0x100
    cyc(0, 32'h0, 1, 1, 0);
    cyc(1, 32'h1100, 0, 0, 0);
    chk("alias_pred", int'(bus.LPresult), 0);
    chk("model_alias_hist", m_ph, 1);

    // Randomized traffic with a small PC pool to force sharing
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/local_predictor.md
Name: local_predictor

Overview:
- Local-history half of the Alpha 21264 tournament predictor. It sits directly upstream of the global/choice stage and supplies that stage's LPresult input.
- Each branch PC selects a per-branch history register in a local history table (LHT). That history then selects a 3-bit saturating counter in the local prediction table (LPT); the counter MSB is the prediction.
- One branch is outstanding at a time. Each prediction is resolved by the next BranchTaken update.

Parameters:
- PC_W, 32, branch address width
- LHT_IDX_W, 10, LHT index width; the LHT has 2**LHT_IDX_W entries, indexed by PC[LHT_IDX_W+1:2]
- HIST_W, 10, per-branch history width; the LPT has 2**HIST_W entries
- CNT_W, 3, LPT counter width
- CNT_INIT, 3, counter reset value (weakly not-taken)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- PredictValid  in  1  request a prediction for PC this cycle
- PC  in  PC_W  branch address
- UpdateValid  in  1  resolve the pending branch this cycle
- BranchTaken  in  1  actual outcome; valid only when UpdateValid=1
- LPresult  out  1  registered local prediction
- LPvalid  out  1  high for one cycle when LPresult is new

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset effects (while reset=1, at each rising edge):
  - all LHT entries are set to 0
  - all LPT counters are set to CNT_INIT
  - LPresult=0, LPvalid=0
  - pending flag is cleared
  - reset overrides any predict or update in the same cycle
- Predict, cycle N (PredictValid=1):
  - idx = PC[LHT_IDX_W+1:2]; h = LHT[idx]
  - at edge N+1: LPresult = LPT[h][CNT_W-1], LPvalid=1
  - the stage latches PendIdx=idx, PendHist=h and sets pending=1
  - a new predict overwrites any unresolved pending entry; the old entry is dropped with no update
- LPvalid is 0 in any cycle following a non-predict cycle. LPresult holds its last value.
- Update, cycle N (UpdateValid=1 and pending=1), at edge N+1:
  - LPT[PendHist] saturating +1 if taken, -1 if not taken; stays at 7 or 0 at the limits
  - LHT[PendIdx] = {LHT[PendIdx][HIST_W-2:0], BranchTaken}
  - pending cleared unless a predict occurs in the same cycle
- An UpdateValid with pending=0 is ignored; the tables are unchanged.
- Predict and update in the same cycle:
  - the update uses the old pending state
  - the prediction sees post-update state via bypass: if idx==PendIdx, use the shifted history
  - if the resulting h==PendHist, use the updated counter
  - the new pending state is then latched
- Aliasing: PCs with equal index bits share one LHT entry. This is intentional and not detected.
- No X propagation: BranchTaken is ignored when UpdateValid=0.
- Latency: prediction is 1 cycle; table updates are visible to a predict in the next cycle, or the same cycle via bypass.

Decomposition:
- Package tournament_pkg holds:
  - width constants: PC_W, LHT_IDX_W, HIST_W, CNT_W, CNT_INIT
  - typedefs hist_t, cnt_t, lht_idx_t
  - function sat_update(cnt_t, logic taken)
  - function lht_index(PC)
- tournament_pkg is shared with the global/choice stage, whose counters reuse sat_update.
- One sub-module, local_history_table, holds the LHT array, its reset and the shift-in write. The counter table, pending register and bypass stay in local_predictor.

Test Plan:
- Reset check: assert reset for 4 cycles, then predict PC=0x100 → LPvalid=1, LPresult=0 (LPT[0]=3), LHT[0x40]=0.
- Always-taken: 20 sequences of (predict PC=0x100, then update taken next cycle) → predictions 0..10 are 0 and 11..19 are 1; LHT[0x40]=0x3FF; LPT[0x3FF]=7 (saturated, not 8 or wrapped).
- Always-taken then not-taken: after the 20 taken, 20 not-taken on PC=0x100 → LHT[0x40]=0x000 after 10 updates; LPT[0x3FF] decrements only via entries using history 0x3FF; no counter underflows below 0.
- Bypass: predict PC=0x100 in cycle N; in cycle N+1 assert UpdateValid (taken) together with PredictValid on PC=0x100 → the prediction reads history 0x001, not 0x000.
- Spurious and overwritten updates: UpdateValid with no pending (right after reset) → no table change. Two predicts on PC=0x100 then PC=0x200 before any update → a single update writes only LHT[0x80].
- Reset mid-operation and aliasing: assert reset while pending=1 with UpdateValid=1 → tables cleared and the update is discarded. PC=0x100 and PC=0x1100 share LHT index 0x40: one taken update via 0x100, then predict 0x1100 → reads history 0x001.
